// File: rtl/axis_sts_mon_s2mm.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | axis_sts_mon_s2mm: AXI DataMover S2MM status monitor / capture tracker  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module axis_sts_mon_s2mm #(
   parameter int MAX_BURST_LEN  = 4096,
   parameter int TIMEOUT_CYCLES = 16777216
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  s_axis_sts_tdata,
   input  logic        s_axis_sts_tvalid,
   output logic        s_axis_sts_tready,
   input  logic        s_axis_sts_tkeep,
   input  logic        s_axis_sts_tlast,
   input  logic        write_start,
   input  logic        write_reset,
   input  logic [31:0] cap_size,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [3:0]  err_code,
   output logic        timeout,
   output logic [15:0] sts_count,
   output logic [31:0] bytes_done
);

   localparam int          LOG2_MBL  = $clog2(MAX_BURST_LEN);
   localparam logic [32:0] BURST_M1  = 33'(MAX_BURST_LEN - 1);
   localparam logic [31:0] BURST     = 32'(MAX_BURST_LEN);
   localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [31:0] remaining, remaining_next;
   logic [31:0] tmo_cnt, tmo_next;
   logic        done_next;
   logic [3:0]  err_code_next;
   logic        timeout_next;
   logic [15:0] sts_count_next;
   logic [31:0] bytes_done_next;

   logic [32:0] expected;
   logic [31:0] chunk;
   logic        beat;
   logic        okay;
   logic [2:0]  flags;
   logic        bad;
   logic        unused;

   assign s_axis_sts_tready = ~reset;
   assign beat     = s_axis_sts_tvalid & s_axis_sts_tready;
   assign okay     = s_axis_sts_tdata[7];
   assign flags    = {s_axis_sts_tdata[4], s_axis_sts_tdata[5], s_axis_sts_tdata[6]};
   assign bad      = ~okay | (|flags);
   assign expected = ({1'b0, cap_size} + BURST_M1) >> LOG2_MBL;
   assign chunk    = (remaining < BURST) ? remaining : BURST;
   assign unused   = ^{s_axis_sts_tkeep, s_axis_sts_tlast, s_axis_sts_tdata[3:0]};

   assign busy  = (state == RUN);
   assign error = (state == ERR);

   always_comb begin
      state_next      = state;
      remaining_next  = remaining;
      tmo_next        = tmo_cnt;
      done_next       = 1'b0;
      err_code_next   = err_code;
      timeout_next    = timeout;
      sts_count_next  = sts_count;
      bytes_done_next = bytes_done;
      if (write_reset) begin
         state_next      = IDLE;
         remaining_next  = '0;
         tmo_next        = '0;
         err_code_next   = '0;
         timeout_next    = 1'b0;
         sts_count_next  = '0;
         bytes_done_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (write_start) begin
                  remaining_next  = cap_size;
                  tmo_next        = '0;
                  sts_count_next  = '0;
                  bytes_done_next = '0;
                  if (expected == 33'd0) done_next  = 1'b1;
                  else                   state_next = RUN;
               end else if (beat) begin
                  err_code_next[3] = 1'b1;
                  state_next       = ERR;
               end
            end
            RUN: begin
               if (beat) begin
                  if (bad) begin
                     err_code_next[2:0] = err_code[2:0] | flags;
                     // OKAY low with no explicit flag is reported as a slave error
                     if (flags == 3'b000) err_code_next[0] = 1'b1;
                     state_next = ERR;
                  end else begin
                     tmo_next        = '0;
                     sts_count_next  = (sts_count == 16'hFFFF) ? sts_count : sts_count + 16'd1;
                     bytes_done_next = bytes_done + chunk;
                     remaining_next  = remaining - chunk;
                     // last chunk fits in one burst exactly when this is beat number 'expected'
                     if (remaining <= BURST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                     end
                  end
               end else if (TMO_LIMIT != 32'd0) begin
                  if (tmo_cnt + 32'd1 == TMO_LIMIT) begin
                     timeout_next = 1'b1;
                     state_next   = ERR;
                  end else begin
                     tmo_next = tmo_cnt + 32'd1;
                  end
               end
            end
            ERR: begin
               state_next = ERR;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         remaining  <= '0;
         tmo_cnt    <= '0;
         done       <= 1'b0;
         err_code   <= '0;
         timeout    <= 1'b0;
         sts_count  <= '0;
         bytes_done <= '0;
      end else begin
         state      <= state_next;
         remaining  <= remaining_next;
         tmo_cnt    <= tmo_next;
         done       <= done_next;
         err_code   <= err_code_next;
         timeout    <= timeout_next;
         sts_count  <= sts_count_next;
         bytes_done <= bytes_done_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_sts_mon_s2mm.sv
`default_nettype none
// Testbench for axis_sts_mon_s2mm: vector table plus timeout corner sequences,
// expected outputs queued at drive time and compared after each clock edge.
module tb_axis_sts_mon_s2mm;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tready;
   logic        write_start;
   logic        write_reset;
   logic [31:0] cap_size;
   logic        busy, done, error, timeout;
   logic [3:0]  err_code;
   logic [15:0] sts_count;
   logic [31:0] bytes_done;

   always #5 clk = ~clk;

   axis_sts_mon_s2mm #(
      .MAX_BURST_LEN (4096),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .s_axis_sts_tdata (tdata),
      .s_axis_sts_tvalid(tvalid),
      .s_axis_sts_tready(tready),
      .s_axis_sts_tkeep (1'b1),
      .s_axis_sts_tlast (1'b1),
      .write_start      (write_start),
      .write_reset      (write_reset),
      .cap_size         (cap_size),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .err_code         (err_code),
      .timeout          (timeout),
      .sts_count        (sts_count),
      .bytes_done       (bytes_done)
   );

   typedef struct {
      logic        busy, done, err;
      logic [3:0]  ec;
      logic        to;
      logic [15:0] cnt;
      logic [31:0] bytes;
   } exp_t;

   typedef struct {
      logic        wr, st;
      logic [31:0] cap;
      logic        v;
      logic [7:0]  d;
      exp_t        e;
   } vec_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(logic wr, logic st, logic [31:0] cap, logic v, logic [7:0] d,
                               logic b, logic dn, logic er, logic [3:0] ec, logic to,
                               logic [15:0] cnt, logic [31:0] bytes);
      vec_t r;
      r.wr = wr; r.st = st; r.cap = cap; r.v = v; r.d = d;
      r.e.busy = b; r.e.done = dn; r.e.err = er; r.e.ec = ec; r.e.to = to;
      r.e.cnt = cnt; r.e.bytes = bytes;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h, want %0h", name, idx, act, exp);
      end
   endtask

   task automatic step(input vec_t vv, input int idx);
      exp_t e;
      @(negedge clk);
      write_reset = vv.wr;
      write_start = vv.st;
      cap_size    = vv.cap;
      tvalid      = vv.v;
      tdata       = vv.d;
      sb.push_back(vv.e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("busy",       idx, 32'(busy),       32'(e.busy));
      chk("done",       idx, 32'(done),       32'(e.done));
      chk("error",      idx, 32'(error),      32'(e.err));
      chk("err_code",   idx, 32'(err_code),   32'(e.ec));
      chk("timeout",    idx, 32'(timeout),    32'(e.to));
      chk("sts_count",  idx, 32'(sts_count),  32'(e.cnt));
      chk("bytes_done", idx, 32'(bytes_done), 32'(e.bytes));
      chk("tready",     idx, 32'(tready),     32'd1);
   endtask

   initial begin
      reset = 1'b1; write_reset = 1'b0; write_start = 1'b0;
      cap_size = '0; tvalid = 1'b0; tdata = '0;

      //                 wr st cap    v  d      busy dn er ec       to cnt bytes
      // capture of 10000 bytes in three beats
      tbl.push_back(mk(0, 1, 10000, 0, 8'h00, 1, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,     1, 8'h80, 1, 0, 0, 4'b0000, 0, 1, 4096));
      tbl.push_back(mk(0, 0, 0,     1, 8'h83, 1, 0, 0, 4'b0000, 0, 2, 8192));
      tbl.push_back(mk(0, 0, 0,     1, 8'h8F, 0, 1, 0, 4'b0000, 0, 3, 10000));
      tbl.push_back(mk(0, 0, 0,     0, 8'h00, 0, 0, 0, 4'b0000, 0, 3, 10000));
      // SLVERR on first beat, later beat discarded, start ignored in ERR
      tbl.push_back(mk(0, 1, 8192,  0, 8'h00, 1, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,     1, 8'hC0, 0, 0, 1, 4'b0001, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,     1, 8'h80, 0, 0, 1, 4'b0001, 0, 0, 0));
      tbl.push_back(mk(0, 1, 100,   0, 8'h00, 0, 0, 1, 4'b0001, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0,     0, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 0));
      // unexpected beat in IDLE, then a zero-size capture
      tbl.push_back(mk(0, 0, 0,     1, 8'h80, 0, 0, 1, 4'b1000, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0,     0, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0,     0, 8'h00, 0, 1, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,     0, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 0));
      // DECERR+INTERR with OKAY set, then OKAY=0 with no flags
      tbl.push_back(mk(0, 1, 4096,  0, 8'h00, 1, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,     1, 8'hB5, 0, 0, 1, 4'b0110, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0,     0, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 1, 4096,  0, 8'h00, 1, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,     1, 8'h00, 0, 0, 1, 4'b0001, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0,     0, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 0));
      // write_reset wins over a simultaneous beat and start
      tbl.push_back(mk(0, 1, 10000, 0, 8'h00, 1, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,     1, 8'h80, 1, 0, 0, 4'b0000, 0, 1, 4096));
      tbl.push_back(mk(1, 1, 10000, 1, 8'h80, 0, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,     0, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 0));

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("tready_in_reset", 0, 32'(tready), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_busy",  0, 32'(busy),       32'd0);
      chk("rst_done",  0, 32'(done),       32'd0);
      chk("rst_error", 0, 32'(error),      32'd0);
      chk("rst_ec",    0, 32'(err_code),   32'd0);
      chk("rst_to",    0, 32'(timeout),    32'd0);
      chk("rst_cnt",   0, 32'(sts_count),  32'd0);
      chk("rst_bytes", 0, 32'(bytes_done), 32'd0);
      chk("rst_tready",0, 32'(tready),     32'd1);

      foreach (tbl[i]) step(tbl[i], i);

      // timeout exactly 16 cycles after entering RUN
      step(mk(0, 1, 8192, 0, 8'h00, 1, 0, 0, 4'b0000, 0, 0, 0), 100);
      for (int k = 1; k <= 16; k++)
         step(mk(0, 0, 0, 0, 8'h00, k < 16, 0, k == 16, 4'b0000, k == 16, 0, 0), 100 + k);
      step(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 0), 117);

      // final beat coincides with timeout expiry: beat wins
      step(mk(0, 1, 4096, 0, 8'h00, 1, 0, 0, 4'b0000, 0, 0, 0), 200);
      for (int k = 1; k <= 15; k++)
         step(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 4'b0000, 0, 0, 0), 200 + k);
      step(mk(0, 0, 0, 1, 8'h80, 0, 1, 0, 4'b0000, 0, 1, 4096), 216);
      step(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 4'b0000, 0, 1, 4096), 217);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
